svc_uart_echo_checker: RTL and testbench

//   Host-side partner for the SoC UART echo program. Serialises bytes from a

---
 rtl/svc_uart_echo_checker.sv | 238 +++++++++++++++++++++++
 tb/tb_svc_uart_echo_checker.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/svc_uart_echo_checker.sv
// UART echo checker: serialises s_* bytes onto txd (8N1), scores echoed rxd bytes against an expected FIFO.
// Tx starts the cycle after accept; s_ready drops while a frame is on the wire or the expected FIFO is full.
module svc_uart_echo_checker #(
  parameter int CLOCK_FREQ     = 1_000_000,
  parameter int BAUD_RATE      = 115_200,
  parameter int DEPTH          = 16,
  parameter int TIMEOUT_CYCLES = 100_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [7:0]  s_data,
  output logic        txd,
  input  logic        rxd,
  input  logic        clear,
  output logic        busy,
  output logic [15:0] match_cnt,
  output logic [15:0] mismatch_cnt,
  output logic        timeout_err,
  output logic [7:0]  last_exp,
  output logic [7:0]  last_got
);
  localparam int CPB = CLOCK_FREQ / BAUD_RATE;
  localparam int CW  = $clog2(CPB);
  localparam int AW  = $clog2(DEPTH);
  localparam int TW  = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CPB - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CPB / 2 - 1);
  localparam logic [AW:0]   DEPTH_C   = (AW + 1)'(DEPTH);
  localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_e;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT} rx_state_e;

  tx_state_e        tx_state_q, tx_state_d;
  logic [CW-1:0]    tx_cyc_q, tx_cyc_d;
  logic [2:0]       tx_idx_q, tx_idx_d;
  logic [7:0]       tx_sh_q, tx_sh_d;
  logic             rdy_en_q;

  rx_state_e        rx_state_q, rx_state_d;
  logic [CW-1:0]    rx_cyc_q, rx_cyc_d;
  logic [2:0]       rx_idx_q, rx_idx_d;
  logic [7:0]       rx_sh_q, rx_sh_d;
  logic             rx_s1_q, rx_s2_q, rx_prev_q;

  logic [7:0]       mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic [TW-1:0]    timer_q, timer_d;

  logic [15:0]      match_q, match_d, mis_q, mis_d;
  logic             tmo_q, tmo_d;
  logic [7:0]       last_exp_q, last_exp_d, last_got_q, last_got_d;

  logic             push, pop, rx_vld, rx_ferr, expire;
  logic [7:0]       head;

  assign s_ready      = rdy_en_q && (tx_state_q == TX_IDLE) && (count_q < DEPTH_C);
  assign push         = s_valid && s_ready;
  assign head         = mem_q[rd_ptr_q];
  assign pop          = rx_vld && (count_q != '0);
  assign expire       = (count_q != '0) && (timer_q == TMO_LAST) && !rx_vld;
  assign busy         = (tx_state_q != TX_IDLE) || (count_q != '0);
  assign match_cnt    = match_q;
  assign mismatch_cnt = mis_q;
  assign timeout_err  = tmo_q;
  assign last_exp     = last_exp_q;
  assign last_got     = last_got_q;

  always_comb begin
    tx_state_d = tx_state_q;
    tx_cyc_d   = tx_cyc_q;
    tx_idx_d   = tx_idx_q;
    tx_sh_d    = tx_sh_q;
    txd        = 1'b1;
    case (tx_state_q)
      TX_IDLE: if (push) begin
        tx_state_d = TX_START;
        tx_cyc_d   = '0;
        tx_sh_d    = s_data;
      end
      TX_START: begin
        txd = 1'b0;
        if (tx_cyc_q == BIT_LAST) begin
          tx_state_d = TX_DATA;
          tx_cyc_d   = '0;
          tx_idx_d   = '0;
        end else tx_cyc_d = tx_cyc_q + 1'b1;
      end
      TX_DATA: begin
        txd = tx_sh_q[0];
        if (tx_cyc_q == BIT_LAST) begin
          tx_cyc_d = '0;
          tx_sh_d  = {1'b0, tx_sh_q[7:1]};
          tx_idx_d = tx_idx_q + 1'b1;
          if (tx_idx_q == 3'd7) tx_state_d = TX_STOP;
        end else tx_cyc_d = tx_cyc_q + 1'b1;
      end
      TX_STOP: begin
        if (tx_cyc_q == BIT_LAST) begin
          tx_state_d = TX_IDLE;
          tx_cyc_d   = '0;
        end else tx_cyc_d = tx_cyc_q + 1'b1;
      end
      default: tx_state_d = TX_IDLE;
    endcase
  end

  always_comb begin
    rx_state_d = rx_state_q;
    rx_cyc_d   = rx_cyc_q;
    rx_idx_d   = rx_idx_q;
    rx_sh_d    = rx_sh_q;
    rx_vld     = 1'b0;
    rx_ferr    = 1'b0;
    case (rx_state_q)
      RX_IDLE: if (rx_prev_q && !rx_s2_q) begin
        rx_state_d = RX_START;
        rx_cyc_d   = '0;
      end
      // A start bit that has gone high again by mid-bit is a glitch.
      RX_START: begin
        if (rx_cyc_q == HALF_LAST) begin
          rx_cyc_d   = '0;
          rx_idx_d   = '0;
          rx_state_d = rx_s2_q ? RX_IDLE : RX_DATA;
        end else rx_cyc_d = rx_cyc_q + 1'b1;
      end
      RX_DATA: begin
        if (rx_cyc_q == BIT_LAST) begin
          rx_cyc_d = '0;
          rx_sh_d  = {rx_s2_q, rx_sh_q[7:1]};
          rx_idx_d = rx_idx_q + 1'b1;
          if (rx_idx_q == 3'd7) rx_state_d = RX_STOP;
        end else rx_cyc_d = rx_cyc_q + 1'b1;
      end
      RX_STOP: begin
        if (rx_cyc_q == BIT_LAST) begin
          rx_cyc_d = '0;
          if (rx_s2_q) begin
            rx_vld     = 1'b1;
            rx_state_d = RX_IDLE;
          end else begin
            rx_ferr    = 1'b1;
            rx_state_d = RX_WAIT;
          end
        end else rx_cyc_d = rx_cyc_q + 1'b1;
      end
      RX_WAIT: if (rx_s2_q) rx_state_d = RX_IDLE;
      default: rx_state_d = RX_IDLE;
    endcase
  end

  always_comb begin
    wr_ptr_d   = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d   = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d    = count_q + (AW + 1)'(push) - (AW + 1)'(pop);
    timer_d    = (count_q == '0 || rx_vld || expire) ? '0 : timer_q + 1'b1;
    match_d    = match_q;
    mis_d      = mis_q;
    tmo_d      = tmo_q || expire;
    last_exp_d = last_exp_q;
    last_got_d = last_got_q;
    // A flush discards everything already queued but keeps a same-cycle push.
    if (expire) begin
      rd_ptr_d = wr_ptr_q;
      count_d  = (AW + 1)'(push);
    end
    if (pop && rx_sh_q == head) begin
      match_d = (match_q == 16'hFFFF) ? match_q : match_q + 1'b1;
    end else if (rx_ferr || rx_vld) begin
      mis_d      = (mis_q == 16'hFFFF) ? mis_q : mis_q + 1'b1;
      last_exp_d = pop ? head : 8'h00;
      last_got_d = rx_sh_q;
    end
    if (clear) begin
      match_d    = '0;
      mis_d      = '0;
      tmo_d      = 1'b0;
      last_exp_d = '0;
      last_got_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= s_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state_q <= TX_IDLE;
      tx_cyc_q   <= '0;
      tx_idx_q   <= '0;
      tx_sh_q    <= '0;
      rdy_en_q   <= 1'b0;
      rx_state_q <= RX_IDLE;
      rx_cyc_q   <= '0;
      rx_idx_q   <= '0;
      rx_sh_q    <= '0;
      rx_s1_q    <= 1'b1;
      rx_s2_q    <= 1'b1;
      rx_prev_q  <= 1'b1;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      timer_q    <= '0;
      match_q    <= '0;
      mis_q      <= '0;
      tmo_q      <= 1'b0;
      last_exp_q <= '0;
      last_got_q <= '0;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cyc_q   <= tx_cyc_d;
      tx_idx_q   <= tx_idx_d;
      tx_sh_q    <= tx_sh_d;
      rdy_en_q   <= 1'b1;
      rx_state_q <= rx_state_d;
      rx_cyc_q   <= rx_cyc_d;
      rx_idx_q   <= rx_idx_d;
      rx_sh_q    <= rx_sh_d;
      rx_s1_q    <= rxd;
      rx_s2_q    <= rx_s1_q;
      rx_prev_q  <= rx_s2_q;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      timer_q    <= timer_d;
      match_q    <= match_d;
      mis_q      <= mis_d;
      tmo_q      <= tmo_d;
      last_exp_q <= last_exp_d;
      last_got_q <= last_got_d;
    end
  end
endmodule

// File: tb/tb_svc_uart_echo_checker.sv
// Directed bench for svc_uart_echo_checker at CPB=8, DEPTH=4, TIMEOUT_CYCLES=500.
module tb_svc_uart_echo_checker;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        s_valid;
  logic        s_ready;
  logic [7:0]  s_data;
  logic        txd;
  logic        rxd;
  logic        clear;
  logic        busy;
  logic [15:0] match_cnt;
  logic [15:0] mismatch_cnt;
  logic        timeout_err;
  logic [7:0]  last_exp;
  logic [7:0]  last_got;

  logic        loop_mode;
  logic        rxd_drv;
  int          checks = 0;
  int          errors = 0;
  int          acc_cnt = 0;

  assign rxd = loop_mode ? txd : rxd_drv;

  svc_uart_echo_checker #(
    .CLOCK_FREQ(1_000_000), .BAUD_RATE(115_200), .DEPTH(4), .TIMEOUT_CYCLES(500)
  ) dut (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .txd(txd), .rxd(rxd), .clear(clear), .busy(busy), .match_cnt(match_cnt),
    .mismatch_cnt(mismatch_cnt), .timeout_err(timeout_err), .last_exp(last_exp),
    .last_got(last_got)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (s_valid && s_ready) acc_cnt++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    s_data  = b;
    s_valid = 1'b1;
    @(negedge clk);
    while (!s_ready && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("send_ready", s_ready, 1);
    @(posedge clk);
    #1;
    s_valid = 1'b0;
  endtask

  task automatic rx_frame(input logic [7:0] b, input logic stop);
    rxd_drv = 1'b0;
    tick(8);
    for (int i = 0; i < 8; i++) begin
      rxd_drv = b[i];
      tick(8);
    end
    rxd_drv = stop;
    tick(8);
    rxd_drv = 1'b1;
  endtask

  task automatic tx_frame_check(input logic [7:0] b);
    logic [7:0] cap = '0;
    send_byte(b);
    chk("tx_start_e0", txd, 0);
    tick(4);
    chk("tx_start_mid", txd, 0);
    for (int k = 0; k < 8; k++) begin
      tick(8);
      cap[k] = txd;
    end
    chk("tx_serial", cap, b);
    tick(8);
    chk("tx_stop", txd, 1);
    tick(3);
    chk("rdy_e79", s_ready, 0);
    tick(1);
    chk("rdy_e80", s_ready, 1);
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    tick(1);
    clear = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy && n < 1000) begin
      tick(1);
      n++;
    end
    chk(tag, busy, 0);
  endtask

  initial begin
    int base;
    rst_n = 1'b0; s_valid = 1'b0; s_data = '0; clear = 1'b0;
    loop_mode = 1'b0; rxd_drv = 1'b1;
    tick(3);
    chk("rst_txd", txd, 1);
    chk("rst_ready", s_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_match", match_cnt, 0);
    chk("rst_mis", mismatch_cnt, 0);
    chk("rst_tmo", timeout_err, 0);
    chk("rst_last", {last_exp, last_got}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rdy_before_edge", s_ready, 0);
    @(posedge clk);
    #1;
    chk("rdy_after_edge", s_ready, 1);

    // Loopback "Hi"
    loop_mode = 1'b1;
    tx_frame_check(8'h48);
    tx_frame_check(8'h69);
    wait_idle("loop_idle");
    tick(5);
    chk("loop_match", match_cnt, 2);
    chk("loop_mis", mismatch_cnt, 0);
    chk("loop_busy", busy, 0);

    // Echo with bit0 of the second byte flipped
    loop_mode = 1'b0;
    pulse_clear();
    chk("clr_match", match_cnt, 0);
    send_byte(8'h48);
    rx_frame(8'h48, 1'b1);
    send_byte(8'h69);
    rx_frame(8'h68, 1'b1);
    tick(4);
    chk("flip_match", match_cnt, 1);
    chk("flip_mis", mismatch_cnt, 1);
    chk("flip_exp", last_exp, 8'h69);
    chk("flip_got", last_got, 8'h68);

    // Unexpected byte, framing error, recovery, glitch
    pulse_clear();
    chk("clr_last", {last_exp, last_got}, 0);
    rx_frame(8'h55, 1'b1);
    tick(4);
    chk("unexp_mis", mismatch_cnt, 1);
    chk("unexp_exp", last_exp, 8'h00);
    chk("unexp_got", last_got, 8'h55);
    rx_frame(8'h55, 1'b0);
    tick(4);
    chk("ferr_mis", mismatch_cnt, 2);
    chk("ferr_got", last_got, 8'h55);
    rx_frame(8'hA3, 1'b1);
    tick(4);
    chk("after_ferr_mis", mismatch_cnt, 3);
    chk("after_ferr_got", last_got, 8'hA3);
    rxd_drv = 1'b0;
    tick(1);
    rxd_drv = 1'b1;
    tick(30);
    chk("glitch_mis", mismatch_cnt, 3);
    chk("glitch_match", match_cnt, 0);

    // Echo timeout
    pulse_clear();
    send_byte(8'h41);
    tick(499);
    chk("tmo_e499", timeout_err, 0);
    chk("tmo_busy_e499", busy, 1);
    tick(1);
    chk("tmo_e500", timeout_err, 1);
    chk("tmo_flushed", busy, 0);
    chk("tmo_match", match_cnt, 0);
    chk("tmo_mis", mismatch_cnt, 0);

    // Full expected FIFO backpressure
    pulse_clear();
    chk("clr_tmo", timeout_err, 0);
    base = acc_cnt;
    s_data = 8'h11;
    s_valid = 1'b1;
    tick(340);
    chk("full_accepts", acc_cnt - base, 4);
    chk("full_ready", s_ready, 0);
    s_valid = 1'b0;
    rx_frame(8'h11, 1'b1);
    tick(2);
    chk("pop_ready", s_ready, 1);
    chk("pop_match", match_cnt, 1);
    for (int i = 0; i < 3; i++) rx_frame(8'h11, 1'b1);
    tick(4);
    chk("drain_match", match_cnt, 4);
    chk("drain_mis", mismatch_cnt, 0);
    chk("drain_busy", busy, 0);

    // Reset mid-frame with an rxd glitch
    rx_frame(8'h5A, 1'b1);
    tick(4);
    chk("pre_rst_mis", mismatch_cnt, 1);
    send_byte(8'h33);
    tick(30);
    rxd_drv = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_txd", txd, 1);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_mis", mismatch_cnt, 0);
    chk("mid_rst_last", {last_exp, last_got}, 0);
    chk("mid_rst_ready", s_ready, 0);
    tick(1);
    rxd_drv = 1'b1;
    tick(2);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_ready", s_ready, 1);
    tick(30);
    chk("post_rst_mis", mismatch_cnt, 0);
    chk("post_rst_match", match_cnt, 0);
    chk("post_rst_txd", txd, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
